hmmm_loader: RTL and testbench

HMMM_LOADER -- requirements
Module: hmmm_loader

---
 rtl/hmmm_pkg.sv | 19 +
 rtl/hmmm_loader.sv | 166 ++++++++++++++++
 tb/tb_hmmm_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hmmm_pkg.sv
// Shared constants for the HMMM program loader: command opcodes, CTRL argument bit and FSM states.
package hmmm_pkg;

    localparam logic [1:0] OpSetAddr = 2'b00;
    localparam logic [1:0] OpWrite   = 2'b01;
    localparam logic [1:0] OpRead    = 2'b10;
    localparam logic [1:0] OpCtrl    = 2'b11;

    localparam int unsigned CtrlRunBit = 0;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StWr   = 3'd1,
        StRd   = 3'd2,
        StRdw  = 3'd3,
        StRsp  = 3'd4
    } state_e;

endpackage

// File: rtl/hmmm_loader.sv
// Loads and reads back HMMM program memory over a command/response stream while holding the CPU
// in reset; tracks a running checksum of written words and a sticky error for misuse while running.
module hmmm_loader
    import hmmm_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rst,
    output logic [DATA_W-1:0] checksum,
    output logic              err
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              err_q, err_d;

    logic accept;
    logic running;

    assign accept  = cmd_valid && cmd_ready;
    assign running = !cpu_rst_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory commands while running never leave idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !running) begin
                    if (cmd_op == OpWrite) begin
                        state_d = StWr;
                    end else if (cmd_op == OpRead) begin
                        state_d = StRd;
                    end
                end
            end
            StWr:    state_d = StIdle;
            StRd:    state_d = StRdw;
            StRdw:   state_d = StRsp;
            StRsp:   state_d = rsp_ready ? StIdle : StRsp;
            default: state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle:  cmd_ready = 1'b1;
            StWr:    mem_we    = 1'b1;
            StRd:    mem_re    = 1'b1;
            StRdw:   ;
            StRsp:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        addr_d     = addr_q;
        checksum_d = checksum_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        cpu_rst_d  = cpu_rst_q;
        err_d      = err_q;

        if (accept) begin
            unique case (cmd_op)
                OpSetAddr: begin
                    addr_d     = cmd_data[ADDR_W-1:0];
                    checksum_d = '0;
                end
                OpWrite: begin
                    if (running) begin
                        err_d = 1'b1;
                    end else begin
                        wdata_d = cmd_data;
                    end
                end
                OpRead: begin
                    if (running) begin
                        err_d = 1'b1;
                    end
                end
                OpCtrl: begin
                    if (cmd_data[CtrlRunBit]) begin
                        cpu_rst_d = 1'b0;
                    end else begin
                        cpu_rst_d = 1'b1;
                        err_d     = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Address wraps naturally at 2^ADDR_W
        if (state_q == StWr) begin
            checksum_d = checksum_q + wdata_q;
            addr_d     = addr_q + 1'b1;
        end
        if (state_q == StRd) begin
            addr_d = addr_q + 1'b1;
        end
        if (state_q == StRdw) begin
            rsp_data_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            checksum_q <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            cpu_rst_q  <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            checksum_q <= checksum_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            cpu_rst_q  <= cpu_rst_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_data  = rsp_data_q;
    assign checksum  = checksum_q;
    assign cpu_rst   = cpu_rst_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hmmm_loader.sv
// Directed bench for hmmm_loader: a default instance plus an ADDR_W=4 instance for address wrap.
module tb_hmmm_loader;
    import hmmm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_ready;

    logic        cmd_ready, rsp_valid, mem_we, mem_re, cpu_rst, err;
    logic [15:0] rsp_data, mem_wdata, checksum;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;

    logic        cmd_ready4, rsp_valid4, mem_we4, mem_re4, cpu_rst4, err4;
    logic [15:0] rsp_data4, mem_wdata4, checksum4;
    logic [15:0] mem_rdata4;
    logic [3:0]  mem_addr4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int overlap  = 0;

    logic [15:0] mem [256];
    logic [7:0]  wlog_addr [$];
    logic [15:0] wlog_data [$];
    logic [3:0]  wlog4_addr [$];
    int          acc_cyc [$];

    assign mem_rdata4 = 16'h0;

    hmmm_loader #(.DATA_W(16), .ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_rst(cpu_rst),
        .checksum(checksum), .err(err)
    );

    hmmm_loader #(.DATA_W(16), .ADDR_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data4), .mem_we(mem_we4), .mem_re(mem_re4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4), .cpu_rst(cpu_rst4),
        .checksum(checksum4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with one-cycle read latency, plus write/accept logs
    always @(posedge clk) begin
        cyc++;
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we4) wlog4_addr.push_back(mem_addr4);
        if (mem_we && mem_re) overlap++;
        if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns #1 after the accepting edge, i.e. inside cycle N+1
    task automatic send(input logic [1:0] op, input logic [15:0] d);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("cmd_accept", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [15:0] exp);
        int t = 0;
        send(OpRead, 16'h0);
        while (!rsp_valid && t < 10) begin
            @(posedge clk);
            #1 t++;
        end
        check_eq({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check_eq(tag, {16'b0, rsp_data}, {16'b0, exp});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_w [3];
        int t;
        exp_w[0] = 16'h1F64;
        exp_w[1] = 16'h0101;
        exp_w[2] = 16'hBE07;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 16'h0; rsp_ready = 1'b0;
        #12;
        check_eq("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check_eq("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        check_eq("rst_checksum", {16'b0, checksum}, 32'd0);
        check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("rst_strobes", {30'b0, mem_we, mem_re}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("post_rst_ready", {31'b0, cmd_ready}, 32'd1);

        // Three writes from address 0
        send(OpSetAddr, 16'h0000);
        wlog_addr.delete(); wlog_data.delete();
        send(OpWrite, 16'h1F64);
        check_eq("wr_we", {31'b0, mem_we}, 32'd1);
        check_eq("wr_addr", {24'b0, mem_addr}, 32'd0);
        check_eq("wr_wdata", {16'b0, mem_wdata}, 32'h1F64);
        check_eq("wr_busy", {31'b0, cmd_ready}, 32'd0);
        send(OpWrite, 16'h0101);
        send(OpWrite, 16'hBE07);
        @(posedge clk);
        #1 check_eq("wr_count", wlog_addr.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("wr_log_addr", {24'b0, wlog_addr[i]}, i);
            check_eq("wr_log_data", {16'b0, wlog_data[i]}, {16'b0, exp_w[i]});
        end
        check_eq("wr_checksum", {16'b0, checksum}, 32'hDE6C);

        // Read with response held off for five cycles
        send(OpSetAddr, 16'h0000);
        send(OpRead, 16'h0000);
        check_eq("rd_re", {31'b0, mem_re}, 32'd1);
        check_eq("rd_no_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1 check_eq("rdw_no_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 check_eq("rsp_valid_n3", {31'b0, rsp_valid}, 32'd1);
        check_eq("rsp_data", {16'b0, rsp_data}, 32'h1F64);
        repeat (5) begin
            @(posedge clk);
            #1 check_eq("rsp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            check_eq("rsp_hold_data", {16'b0, rsp_data}, 32'h1F64);
            check_eq("rsp_hold_busy", {31'b0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_eq("rsp_done_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("rsp_done_ready", {31'b0, cmd_ready}, 32'd1);
        read_word("rd_next", 16'h0101);

        // Address wrap on the ADDR_W=4 instance
        send(OpSetAddr, 16'h000F);
        wlog4_addr.delete();
        send(OpWrite, 16'h0001);
        send(OpWrite, 16'h0001);
        @(posedge clk);
        #1 check_eq("wrap_count", wlog4_addr.size(), 32'd2);
        check_eq("wrap_addr0", {28'b0, wlog4_addr[0]}, 32'd15);
        check_eq("wrap_addr1", {28'b0, wlog4_addr[1]}, 32'd0);
        check_eq("wrap_checksum", {16'b0, checksum}, 32'd2);

        // Run/stop control and misuse while running
        send(OpCtrl, 16'h0001);
        check_eq("run_cpu_rst", {31'b0, cpu_rst}, 32'd0);
        wlog_addr.delete(); wlog_data.delete();
        send(OpWrite, 16'h1234);
        check_eq("run_wr_err", {31'b0, err}, 32'd1);
        check_eq("run_wr_no_we", {31'b0, mem_we}, 32'd0);
        check_eq("run_wr_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 check_eq("run_wr_nolog", wlog_addr.size(), 32'd0);
        check_eq("run_wr_checksum", {16'b0, checksum}, 32'd2);
        send(OpCtrl, 16'h0001);
        check_eq("run_again_rst", {31'b0, cpu_rst}, 32'd0);
        check_eq("run_again_err", {31'b0, err}, 32'd1);
        send(OpSetAddr, 16'h0020);
        send(OpCtrl, 16'h0000);
        check_eq("stop_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check_eq("stop_err", {31'b0, err}, 32'd0);
        send(OpWrite, 16'h5555);
        check_eq("run_setaddr", {24'b0, mem_addr}, 32'h20);
        check_eq("run_setaddr_we", {31'b0, mem_we}, 32'd1);

        // Asynchronous reset while a response is pending
        send(OpRead, 16'h0000);
        t = 0;
        while (!rsp_valid && t < 10) begin
            @(posedge clk);
            #1 t++;
        end
        check_eq("arst_pre_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("arst_pre_checksum", {16'b0, checksum}, 32'h5555);
        #2 rst_n = 1'b0;
        #1 check_eq("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("arst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check_eq("arst_checksum", {16'b0, checksum}, 32'd0);
        check_eq("arst_rsp_data", {16'b0, rsp_data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("arst_ready", {31'b0, cmd_ready}, 32'd1);

        // Back-to-back writes with cmd_valid held high
        send(OpSetAddr, 16'h0000);
        wlog_addr.delete(); wlog_data.delete(); acc_cyc.delete();
        cmd_valid = 1'b1;
        cmd_op    = OpWrite;
        for (int i = 0; i < 16; i++) begin
            cmd_data = 16'hA000 + 16'(i);
            t = 0;
            @(negedge clk);
            while (!cmd_ready && t < 10) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 check_eq("b2b_count", wlog_addr.size(), 32'd16);
        check_eq("b2b_accepts", acc_cyc.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq("b2b_addr", {24'b0, wlog_addr[i]}, i);
            check_eq("b2b_data", {16'b0, wlog_data[i]}, 32'hA000 + i);
            if (i > 0) check_eq("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd2);
        end

        check_eq("we_re_overlap", overlap, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
